// File: rtl/img_stream_tx.sv
// Frame streamer: reads an IMG_W x IMG_H image from a 1-cycle-latency memory in
// raster order and emits it on a valid/ready stream with a flush marker and last tag.
module img_stream_tx #(
  parameter int W_DATA = 8,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24,
  localparam int N_PIX = IMG_W * IMG_H,
  localparam int AW    = (N_PIX > 1) ? $clog2(N_PIX) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [AW-1:0]     mem_addr,
  input  logic [W_DATA-1:0] mem_rdata,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [W_DATA-1:0] dout_data,
  output logic [1:0]        dout_eot
);

  // Stream handshake: a beat transfers in any cycle with dout_valid & dout_ready;
  // once valid is raised, data and eot[0] hold until that transfer happens.
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       addr_q;
  logic                flush_q;
  logic                done_q;
  logic                inflight_q;
  logic                inflight_last_q;
  logic [1:0]          occ_q;
  logic [W_DATA-1:0]   buf_data_q [2];
  logic                buf_last_q [2];

  logic                pop;
  logic                rd_en;
  logic                last_addr;
  logic                accept;
  logic [2:0]          level;

  assign dout_valid = (occ_q != 2'd0);
  assign pop        = dout_valid & dout_ready;
  assign last_addr  = (addr_q == AW'(N_PIX - 1));
  assign accept     = (state_q == IDLE) && start;

  // Buffer entries plus the read in flight must stay within the 2 slots.
  assign level = {1'b0, occ_q} + {2'b00, inflight_q};
  assign rd_en = (state_q == RUN) && ((level - {2'b00, pop}) < 3'd2);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (rd_en && last_addr) state_d = DRAIN;
      DRAIN:   if (pop && buf_last_q[0]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      flush_q         <= 1'b0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      flush_q         <= accept;
      done_q          <= (state_q == DRAIN) && pop && buf_last_q[0];
      inflight_q      <= rd_en;
      inflight_last_q <= rd_en && last_addr;
      if (accept)
        addr_q <= '0;
      else if (rd_en && !last_addr)
        addr_q <= addr_q + AW'(1);
    end
  end

  // Two-entry FIFO with the head in slot 0; a push lands at slot (occ - pop).
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q         <= 2'd0;
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_last_q[0] <= 1'b0;
      buf_last_q[1] <= 1'b0;
    end else begin
      if (pop) begin
        buf_data_q[0] <= buf_data_q[1];
        buf_last_q[0] <= buf_last_q[1];
      end
      if (inflight_q) begin
        if ((occ_q - {1'b0, pop}) == 2'd0) begin
          buf_data_q[0] <= mem_rdata;
          buf_last_q[0] <= inflight_last_q;
        end else begin
          buf_data_q[1] <= mem_rdata;
          buf_last_q[1] <= inflight_last_q;
        end
      end
      occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  assign mem_rd_en = rd_en;
  assign mem_addr  = addr_q;
  assign dout_data = buf_data_q[0];
  assign dout_eot  = {flush_q, buf_last_q[0] & dout_valid};
  assign done      = done_q;
  assign busy      = (state_q != IDLE) | done_q;

endmodule

// File: tb/tb_img_stream_tx.sv
// Bench for img_stream_tx: a 4x2 frame instance with a scoreboard monitor and a
// 1x1 instance checked with directed cycle expectations.
module tb_img_stream_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4x2 instance
  logic       start, busy, done, mem_rd_en, dout_valid, dout_ready;
  logic [2:0] mem_addr;
  logic [7:0] mem_rdata, dout_data;
  logic [1:0] dout_eot;

  // 1x1 instance
  logic       start1, busy1, done1, mem_rd_en1, dout_valid1, dout_ready1;
  logic [0:0] mem_addr1;
  logic [7:0] mem_rdata1, dout_data1;
  logic [1:0] dout_eot1;

  img_stream_tx #(.W_DATA(8), .IMG_W(4), .IMG_H(2)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_eot(dout_eot)
  );

  img_stream_tx #(.W_DATA(8), .IMG_W(1), .IMG_H(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .mem_rd_en(mem_rd_en1), .mem_addr(mem_addr1), .mem_rdata(mem_rdata1),
    .dout_valid(dout_valid1), .dout_ready(dout_ready1), .dout_data(dout_data1),
    .dout_eot(dout_eot1)
  );

  // Synchronous memories: mem[i] = i+16 for the 4x2 frame, mem[0] = AA for 1x1.
  always @(posedge clk) begin
    if (mem_rd_en)  mem_rdata  <= 8'(mem_addr) + 8'd16;
    if (mem_rd_en1) mem_rdata1 <= (mem_addr1 == 1'b0) ? 8'hAA : 8'h00;
  end

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [8:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame();
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 8'(16 + i)});
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pops, stall stability, eot qualification, read-issue bound.
  int rd_total = 0;
  int pop_total = 0;
  logic stall_prev = 1'b0;
  logic [7:0] prev_data;
  logic [1:0] prev_eot;
  always @(negedge clk) begin
    logic [8:0] e;
    logic pop;
    if (rst) begin
      exp_q.delete();
      rd_total = 0;
      pop_total = 0;
      stall_prev = 1'b0;
    end else begin
      pop = dout_valid & dout_ready;
      if (stall_prev) begin
        chk("stall_valid", 32'(dout_valid), 32'd1);
        chk("stall_data", 32'(dout_data), 32'(prev_data));
        chk("stall_eot", 32'(dout_eot), 32'(prev_eot));
      end
      if (!dout_valid) chk("eot0_unqualified", 32'(dout_eot[0]), 32'd0);
      if (mem_rd_en)
        chk("issue_rule", 32'((rd_total - pop_total - int'(pop)) < 2), 32'd1);
      if (pop) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", 32'(dout_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("pixel_data", 32'(dout_data), 32'(e[7:0]));
          chk("pixel_eot0", 32'(dout_eot[0]), 32'(e[8]));
        end
      end
      if (done) done_cnt++;
      rd_total += int'(mem_rd_en);
      pop_total += int'(pop);
      stall_prev = dout_valid & ~dout_ready;
      prev_data = dout_data;
      prev_eot = dout_eot;
    end
  end

  task automatic wait_done(input int budget, input bit use_pat, input string name);
    logic [31:0] pat;
    bit seen;
    pat = 32'hB2D4_6E39;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (use_pat) dout_ready = pat[i % 32];
      @(negedge clk);
      if (done) seen = 1'b1;
      next();
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_cnt;
    int dc0;
    rst = 1'b1; start = 1'b0; dout_ready = 1'b1; start1 = 1'b0; dout_ready1 = 1'b1;
    repeat (3) next();
    @(negedge clk);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_eot", 32'(dout_eot), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst1_valid", 32'(dout_valid1), 32'd0);
    next();
    rst = 1'b0;
    next();

    // Frame with continuous ready: flush C1, pixels C3..C10, done C11.
    start = 1'b1; push_frame();
    @(negedge clk); next(); start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk("t1_flush", 32'(dout_eot[1]), 32'(c == 1));
      chk("t1_valid", 32'(dout_valid), 32'(c >= 3 && c <= 10));
      chk("t1_busy", 32'(busy), 32'(c <= 11));
      chk("t1_done", 32'(done), 32'(c == 11));
      if (c == 1) begin
        chk("t1_rd_en", 32'(mem_rd_en), 32'd1);
        chk("t1_addr", 32'(mem_addr), 32'd0);
      end
      next();
    end
    chk("t1_drained", 32'(exp_q.size()), 32'd0);

    // Same frame under a fixed pseudo-random ready pattern.
    start = 1'b1; push_frame();
    @(negedge clk); next(); start = 1'b0;
    wait_done(100, 1'b1, "t2_done_timeout");
    dout_ready = 1'b1;
    chk("t2_drained", 32'(exp_q.size()), 32'd0);

    // Ready held low C0..C20: only two reads, head holds pixel 16.
    dout_ready = 1'b0; start = 1'b1; push_frame();
    rd_cnt = 0;
    @(negedge clk); next(); start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      rd_cnt += int'(mem_rd_en);
      if (c == 1) chk("t3_addr0", 32'(mem_addr), 32'd0);
      if (c == 2) chk("t3_addr1", 32'(mem_addr), 32'd1);
      if (c == 20) begin
        chk("t3_hold_valid", 32'(dout_valid), 32'd1);
        chk("t3_hold_data", 32'(dout_data), 32'd16);
      end
      next();
    end
    chk("t3_read_count", 32'(rd_cnt), 32'd2);
    dout_ready = 1'b1;
    for (int c = 21; c <= 28; c++) begin
      @(negedge clk);
      chk("t3_back_to_back", 32'(dout_valid), 32'd1);
      next();
    end
    wait_done(5, 1'b0, "t3_done_timeout");
    chk("t3_drained", 32'(exp_q.size()), 32'd0);

    // Start re-pulsed at C5 is ignored; start at the done cycle begins a new frame.
    dc0 = done_cnt;
    start = 1'b1; push_frame();
    @(negedge clk); next();
    for (int c = 1; c <= 11; c++) begin
      start = (c == 5 || c == 11);
      if (c == 11) push_frame();
      @(negedge clk);
      chk("t4_done", 32'(done), 32'(c == 11));
      next();
    end
    start = 1'b0;
    @(negedge clk);
    chk("t4_reflush", 32'(dout_eot), 32'b10);
    next();
    chk("t4_one_done", 32'(done_cnt - dc0), 32'd1);
    wait_done(30, 1'b0, "t4_done_timeout");
    chk("t4_two_done", 32'(done_cnt - dc0), 32'd2);
    chk("t4_drained", 32'(exp_q.size()), 32'd0);

    // Reset at C6 mid-frame abandons the frame silently.
    start = 1'b1; push_frame();
    @(negedge clk); next(); start = 1'b0;
    repeat (5) next();
    rst = 1'b1;
    @(negedge clk); next();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_valid", 32'(dout_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_rd_en", 32'(mem_rd_en), 32'd0);
    next();
    dc0 = done_cnt;
    repeat (20) next();
    chk("t5_no_done", 32'(done_cnt - dc0), 32'd0);
    start = 1'b1; push_frame();
    @(negedge clk); next(); start = 1'b0;
    @(negedge clk);
    chk("t5_restart_addr", 32'(mem_addr), 32'd0);
    chk("t5_restart_rd", 32'(mem_rd_en), 32'd1);
    chk("t5_restart_flush", 32'(dout_eot), 32'b10);
    next();
    wait_done(20, 1'b0, "t5_done_timeout");
    chk("t5_drained", 32'(exp_q.size()), 32'd0);

    // 1x1 frame: flush and read in C1, pixel AA with eot 01 in C3, done C4.
    start1 = 1'b1;
    @(negedge clk); next(); start1 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("t6_rd_en", 32'(mem_rd_en1), 32'd1);
        chk("t6_addr", 32'(mem_addr1), 32'd0);
        chk("t6_flush", 32'(dout_eot1), 32'b10);
      end
      chk("t6_valid", 32'(dout_valid1), 32'(c == 3));
      if (c == 3) begin
        chk("t6_data", 32'(dout_data1), 32'hAA);
        chk("t6_eot", 32'(dout_eot1), 32'b01);
      end
      chk("t6_done", 32'(done1), 32'(c == 4));
      chk("t6_busy", 32'(busy1), 32'(c <= 4));
      next();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
